spi_frame_rx: RTL and testbench

//  Parametrised SPI-slave frame receiver for the adaptive-filter front end; successor to the fixed 14-bit/2-word link.

---
 rtl/spi_frame_rx.sv | 208 ++++++++++++++++++++
 tb/tb_spi_frame_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI-slave frame receiver for the adaptive-filter front end.
// sck/mosi/cs are oversampled in the clk domain. The block deserialises
// WORD_W-bit words, MSB first, one word per cs-low burst. It hunts for
// HEADER, then collects NUM_CH data words and presents them in parallel
// together with a one-cycle frame strobe.
//
// Optional feature macro: SPI_FRAME_ECHO_EN. When it is defined, miso echoes
// the previous good word MSB first. When it is undefined, miso is tied to 0.
//
// Ports:
//   clk, rst          system clock; synchronous active-high reset
//   sck, mosi, cs     asynchronous SPI slave inputs (cs active-low)
//   miso              echo output (0 unless SPI_FRAME_ECHO_EN)
//   data_out          last complete frame, ch0 in the LSBs
//   frame_valid       1-cycle pulse when data_out updates
//   head_flag         high from header accept until frame end/abort
//   frame_err         1-cycle pulse on a bad word, aborted frame or timeout
//   frame_cnt         good-frame counter, wraps
//
// States:
//   state  | meaning
//   S_HUNT | waiting for a good word equal to HEADER
//   S_DATA | collecting data words into the shadow buffer
module spi_frame_rx #(
  parameter int unsigned       WORD_W      = 14,
  parameter int unsigned       NUM_CH      = 2,
  parameter logic [WORD_W-1:0] HEADER      = WORD_W'('h0FFF),
  parameter int unsigned       TIMEOUT     = 4096,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sck,
  input  logic                       mosi,
  input  logic                       cs,
  output logic                       miso,
  output logic [NUM_CH*WORD_W-1:0]   data_out,
  output logic                       frame_valid,
  output logic                       head_flag,
  output logic                       frame_err,
  output logic [15:0]                frame_cnt
);
  localparam int CNT_W = $clog2(WORD_W + 2);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int DW    = NUM_CH * WORD_W;

  typedef enum logic {S_HUNT, S_DATA} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [WORD_W-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]        ch_idx_q, ch_idx_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [DW-1:0]          shadow_q, shadow_d;
  logic [DW-1:0]          data_out_q, data_out_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   head_flag_q, head_flag_d;
  logic                   frame_err_q, frame_err_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;

  logic sck_s, mosi_s, cs_s;
  logic sck_rise, cs_fall, word_done, good_word, tmo_hit;

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign word_done = cs_s & ~cs_prev_q;
  assign good_word = word_done && (bit_cnt_q == CNT_W'(WORD_W));
  // A word boundary in the same cycle takes precedence over the timeout, so
  // coincident events give a single frame_err pulse.
  assign tmo_hit   = (state_q == S_DATA) && !word_done && (tmo_q == TMO_W'(TIMEOUT - 1));

`ifdef SPI_FRAME_ECHO_EN
  logic [WORD_W-1:0] echo_word_q, echo_word_d;
  logic [WORD_W-1:0] echo_sh_q, echo_sh_d;
  logic              sck_fall;
  assign sck_fall = ~sck_s & sck_prev_q;
  // The shifter is cleared on cs rise, so miso is 0 whenever cs is high.
  assign miso     = echo_sh_q[WORD_W-1];
`else
  assign miso = 1'b0;
`endif

  always_comb begin
    sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], sck};
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], cs};
    sck_prev_d    = sck_s;
    cs_prev_d     = cs_s;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    state_d       = state_q;
    ch_idx_d      = ch_idx_q;
    shadow_d      = shadow_q;
    data_out_d    = data_out_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    head_flag_d   = head_flag_q;
    frame_cnt_d   = frame_cnt_q;
    tmo_d         = (word_done || state_q == S_HUNT) ? '0 : tmo_q + 1'b1;

    if (cs_fall) begin
      bit_cnt_d = '0;
    end else if (sck_rise && !cs_s) begin
      shift_d = {shift_q[WORD_W-2:0], mosi_s};
      if (bit_cnt_q != CNT_W'(WORD_W + 1)) bit_cnt_d = bit_cnt_q + 1'b1;
    end

    case (state_q)
      S_HUNT: begin
        if (word_done && !good_word) begin
          frame_err_d = 1'b1;
        end else if (good_word && shift_q == HEADER) begin
          state_d     = S_DATA;
          ch_idx_d    = '0;
          head_flag_d = 1'b1;
        end
      end
      S_DATA: begin
        if (good_word) begin
          shadow_d[ch_idx_q*WORD_W +: WORD_W] = shift_q;
          if (ch_idx_q == CH_W'(NUM_CH - 1)) begin
            data_out_d    = shadow_d;
            frame_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 16'd1;
            head_flag_d   = 1'b0;
            state_d       = S_HUNT;
          end else begin
            ch_idx_d = ch_idx_q + 1'b1;
          end
        end else if (word_done || tmo_hit) begin
          frame_err_d = 1'b1;
          head_flag_d = 1'b0;
          state_d     = S_HUNT;
        end
      end
      default: state_d = S_HUNT;
    endcase

`ifdef SPI_FRAME_ECHO_EN
    echo_word_d = good_word ? shift_q : echo_word_q;
    echo_sh_d   = echo_sh_q;
    if (word_done)               echo_sh_d = '0;
    else if (cs_fall)            echo_sh_d = echo_word_q;
    else if (sck_fall && !cs_s)  echo_sh_d = {echo_sh_q[WORD_W-2:0], 1'b0};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_HUNT;
      sck_sync_q    <= '0;
      mosi_sync_q   <= '0;
      cs_sync_q     <= '1;
      sck_prev_q    <= 1'b0;
      cs_prev_q     <= 1'b1;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      ch_idx_q      <= '0;
      tmo_q         <= '0;
      shadow_q      <= '0;
      data_out_q    <= '0;
      frame_valid_q <= 1'b0;
      head_flag_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= '0;
`ifdef SPI_FRAME_ECHO_EN
      echo_word_q   <= '0;
      echo_sh_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sck_sync_q    <= sck_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      cs_sync_q     <= cs_sync_d;
      sck_prev_q    <= sck_prev_d;
      cs_prev_q     <= cs_prev_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      ch_idx_q      <= ch_idx_d;
      tmo_q         <= tmo_d;
      shadow_q      <= shadow_d;
      data_out_q    <= data_out_d;
      frame_valid_q <= frame_valid_d;
      head_flag_q   <= head_flag_d;
      frame_err_q   <= frame_err_d;
      frame_cnt_q   <= frame_cnt_d;
`ifdef SPI_FRAME_ECHO_EN
      echo_word_q   <= echo_word_d;
      echo_sh_q     <= echo_sh_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign frame_valid = frame_valid_q;
  assign head_flag   = head_flag_q;
  assign frame_err   = frame_err_q;
  assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx with default parameters. Expected frames
// are queued as {frame_cnt, data_out} when a frame is sent. A monitor records
// observed frame strobes. Both queues are then compared in order.
module tb_spi_frame_rx;
  logic        clk = 1'b0;
  logic        rst, sck, mosi, cs;
  logic        miso, frame_valid, head_flag, frame_err;
  logic [27:0] data_out;
  logic [15:0] frame_cnt;

  int checks = 0;
  int failures = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  int exp_cnt = 0;
  int e0, f0;
  logic [43:0] sb[$];
  logic [43:0] obs_q[$];
  logic [31:0] echo;
  logic [31:0] echo_exp;

  spi_frame_rx dut (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .cs(cs), .miso(miso),
    .data_out(data_out), .frame_valid(frame_valid), .head_flag(head_flag),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        fv_cnt++;
        obs_q.push_back({frame_cnt, data_out});
      end
      if (frame_err) err_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] val, input int nbits, output logic [31:0] ech);
    ech = '0;
    cs = 1'b0;
    tick(6);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = val[i];
      sck = 1'b0;
      tick(6);
      ech = {ech[30:0], miso};
      sck = 1'b1;
      tick(6);
    end
    sck = 1'b0;
    tick(6);
    cs = 1'b1;
    tick(10);
  endtask

  task automatic push_frame(input logic [13:0] ch1, input logic [13:0] ch0);
    exp_cnt++;
    sb.push_back({16'(exp_cnt), ch1, ch0});
  endtask

  task automatic drain();
    int t;
    logic [43:0] e, o;
    t = 0;
    while (obs_q.size() < sb.size() && t < 200) begin
      tick(1);
      t++;
    end
    chk("frame_count_match", 64'(obs_q.size()), 64'(sb.size()));
    while (sb.size() > 0 && obs_q.size() > 0) begin
      e = sb.pop_front();
      o = obs_q.pop_front();
      chk("data_out", 64'(o[27:0]), 64'(e[27:0]));
      chk("frame_cnt", 64'(o[43:28]), 64'(e[43:28]));
    end
  endtask

  task automatic send_t1();
    send_word(32'h0FFF, 14, echo);
    send_word(32'h0123, 14, echo);
    push_frame(14'h3ABC, 14'h0123);
    send_word(32'h3ABC, 14, echo);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    tick(5);
    chk("rst_data_out", 64'(data_out), 64'h0);
    chk("rst_frame_valid", 64'(frame_valid), 64'h0);
    chk("rst_head_flag", 64'(head_flag), 64'h0);
    chk("rst_frame_err", 64'(frame_err), 64'h0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'h0);
    chk("rst_miso", 64'(miso), 64'h0);
    rst = 1'b0;
    tick(5);

    // T1: basic frame
    e0 = err_cnt; f0 = fv_cnt;
    send_word(32'h0FFF, 14, echo);
    chk("t1_head_after_hdr", 64'(head_flag), 64'h1);
    send_word(32'h0123, 14, echo);
    chk("t1_head_mid", 64'(head_flag), 64'h1);
    push_frame(14'h3ABC, 14'h0123);
    send_word(32'h3ABC, 14, echo);
    drain();
    chk("t1_head_end", 64'(head_flag), 64'h0);
    chk("t1_fv_pulses", 64'(fv_cnt - f0), 64'h1);
    chk("t1_err_pulses", 64'(err_cnt - e0), 64'h0);

    // T2: data without a header is ignored
    e0 = err_cnt; f0 = fv_cnt;
    send_word(32'h0123, 14, echo);
    send_word(32'h3ABC, 14, echo);
    chk("t2_fv_pulses", 64'(fv_cnt - f0), 64'h0);
    chk("t2_err_pulses", 64'(err_cnt - e0), 64'h0);
    chk("t2_frame_cnt", 64'(frame_cnt), 64'h1);

    // T3: short word aborts the frame, then recovery
    e0 = err_cnt; f0 = fv_cnt;
    send_word(32'h0FFF, 14, echo);
    send_word(32'h02AA, 10, echo);
    chk("t3_err_pulses", 64'(err_cnt - e0), 64'h1);
    chk("t3_head_cleared", 64'(head_flag), 64'h0);
    chk("t3_data_kept", 64'(data_out), 64'({14'h3ABC, 14'h0123}));
    send_t1();
    drain();
    chk("t3_fv_pulses", 64'(fv_cnt - f0), 64'h1);

    // T4: header value inside the data phase is data
    send_word(32'h0FFF, 14, echo);
    send_word(32'h0FFF, 14, echo);
    push_frame(14'h0001, 14'h0FFF);
    send_word(32'h0001, 14, echo);
    drain();

    // T5: inter-word timeout
    e0 = err_cnt; f0 = fv_cnt;
    send_word(32'h0FFF, 14, echo);
    send_word(32'h0055, 14, echo);
    chk("t5_head_before_tmo", 64'(head_flag), 64'h1);
    tick(4096 + 10);
    chk("t5_err_pulses", 64'(err_cnt - e0), 64'h1);
    chk("t5_head_after_tmo", 64'(head_flag), 64'h0);
    send_t1();
    drain();
    chk("t5_fv_pulses", 64'(fv_cnt - f0), 64'h1);

    // T6: reset mid-frame
    send_word(32'h0FFF, 14, echo);
    send_word(32'h0123, 14, echo);
    cs = 1'b0;
    tick(6);
    for (int i = 13; i >= 9; i--) begin
      mosi = 1'b1;
      sck = 1'b0;
      tick(6);
      sck = 1'b1;
      tick(6);
    end
    rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    tick(3);
    chk("t6_rst_data_out", 64'(data_out), 64'h0);
    chk("t6_rst_head_flag", 64'(head_flag), 64'h0);
    chk("t6_rst_frame_cnt", 64'(frame_cnt), 64'h0);
    chk("t6_rst_frame_err", 64'(frame_err), 64'h0);
    chk("t6_rst_frame_valid", 64'(frame_valid), 64'h0);
    chk("t6_rst_miso", 64'(miso), 64'h0);
    tick(2);
    rst = 1'b0;
    exp_cnt = 0;
    tick(5);
    e0 = err_cnt;
    send_t1();
    drain();
    chk("t6_frame_cnt", 64'(frame_cnt), 64'h1);
`ifdef SPI_FRAME_ECHO_EN
    echo_exp = 32'h3ABC;
`else
    echo_exp = 32'h0;
`endif
    send_word(32'h0000, 14, echo);
    chk("t6_miso_echo", 64'(echo), 64'(echo_exp));
    chk("t6_err_pulses", 64'(err_cnt - e0), 64'h0);
    chk("final_unmatched_frames", 64'(obs_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
